// File: rtl/light_display_rmw_ram.sv
// Brightness RAM with a read-modify-write command pipeline, a zeroing sweep
// on reset or clear, a read-first readout port and a running brightness total.
module light_display_rmw_ram #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int TOTAL_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [DATA_WIDTH-1:0]  cmd_data,
   input  logic                   clear_req,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   init_busy,
   output logic [TOTAL_WIDTH-1:0] total
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] MAX = '1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef enum logic [1:0] {OP_OFF, OP_ON, OP_TOGGLE, OP_WRITE} op_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  s2_valid;
   op_t                   s2_op;
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic [DATA_WIDTH-1:0] s2_data;
   logic [DATA_WIDTH-1:0] s2_old;
   logic [DATA_WIDTH-1:0] new_val;
   logic                  accept;
   logic                  fwd;

   assign cmd_ready = (state == ST_RUN);
   assign init_busy = (state == ST_INIT);
   assign accept    = cmd_valid && cmd_ready;
   assign fwd       = s2_valid && (s2_addr == cmd_addr);

   always_comb begin
      new_val = s2_old;
      case (s2_op)
         OP_OFF:    new_val = (s2_old == '0) ? '0 : s2_old - 1'b1;
         OP_ON:     new_val = (s2_old == MAX) ? MAX : s2_old + 1'b1;
         OP_TOGGLE: new_val = (s2_old >= MAX - 1'b1) ? MAX : s2_old + DATA_WIDTH'(2);
         OP_WRITE:  new_val = s2_data;
         default:   new_val = s2_old;
      endcase
   end

   // Payload and memory carry no reset; the stage-2 write lands before the
   // sweep write in the same cycle, so the sweep's zero wins on a collision.
   always_ff @(posedge clk) begin
      if (accept) begin
         s2_op   <= op_t'(cmd_op);
         s2_addr <= cmd_addr;
         s2_data <= cmd_data;
         s2_old  <= fwd ? new_val : mem[cmd_addr];
      end
      if (rst_n && s2_valid)
         mem[s2_addr] <= new_val;
      if (rst_n && state == ST_INIT)
         mem[init_addr] <= '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         init_addr <= '0;
         total     <= '0;
         rd_data   <= '0;
         s2_valid  <= 1'b0;
      end else begin
         rd_data  <= mem[rd_addr];
         s2_valid <= accept;
         case (state)
            ST_INIT: begin
               init_addr <= init_addr + 1'b1;
               if (init_addr == '1)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (clear_req) begin
                  state     <= ST_INIT;
                  init_addr <= '0;
                  total     <= '0;
               end else if (s2_valid) begin
                  total <= total + TOTAL_WIDTH'(new_val) - TOTAL_WIDTH'(s2_old);
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_light_display_rmw_ram.sv
// Directed bench for light_display_rmw_ram at ADDR_WIDTH=4, DATA_WIDTH=4.
module tb_light_display_rmw_ram;

   localparam int AW = 4;
   localparam int DW = 4;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          clear_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          init_busy;
   logic [TW-1:0] total;

   int tests = 0;
   int fails = 0;

   localparam logic [1:0] OFF = 2'd0, ON = 2'd1, TGL = 2'd2, WR = 2'd3;

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] exp_val;
      logic [TW-1:0] exp_tot;
   } vec_t;

   vec_t vecs [11];

   light_display_rmw_ram #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TOTAL_WIDTH(TW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .clear_req (clear_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .init_busy (init_busy),
      .total     (total)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Counts edges until init_busy drops, bounded.
   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cnt++;
         if (!init_busy) break;
      end
   endtask

   task automatic check_all_zero(input string name);
      int nz;
      nz = 0;
      for (int a = 0; a < 16; a++) begin
         rd_addr = AW'(a);
         tick();
         if (rd_data != '0) nz++;
      end
      check(name, nz, 0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int cnt;

      vecs[0]  = '{OFF, 4'd2,  4'd0,  4'd0,  8'd3};
      vecs[1]  = '{TGL, 4'd2,  4'd0,  4'd2,  8'd5};
      vecs[2]  = '{OFF, 4'd2,  4'd0,  4'd1,  8'd4};
      vecs[3]  = '{WR,  4'd7,  4'd14, 4'd14, 8'd18};
      vecs[4]  = '{TGL, 4'd7,  4'd0,  4'd15, 8'd19};
      vecs[5]  = '{ON,  4'd7,  4'd0,  4'd15, 8'd19};
      vecs[6]  = '{OFF, 4'd5,  4'd9,  4'd2,  8'd18};
      vecs[7]  = '{WR,  4'd7,  4'd0,  4'd0,  8'd3};
      vecs[8]  = '{TGL, 4'd15, 4'd0,  4'd2,  8'd5};
      vecs[9]  = '{WR,  4'd0,  4'd15, 4'd15, 8'd20};
      vecs[10] = '{OFF, 4'd0,  4'd0,  4'd14, 8'd19};

      // Reset state
      tick();
      tick();
      check("reset_init_busy", int'(init_busy), 1);
      check("reset_cmd_ready", int'(cmd_ready), 0);
      check("reset_total",     int'(total), 0);
      check("reset_rd_data",   int'(rd_data), 0);

      rst_n = 1'b1;
      count_busy(cnt);
      check("init_busy_cycles", cnt, 16);
      check("run_cmd_ready", int'(cmd_ready), 1);
      check("run_total", int'(total), 0);
      check_all_zero("init_cells_zero");

      // Back-to-back ON to the same address relies on forwarding
      cmd_valid = 1'b1;
      cmd_op    = ON;
      cmd_addr  = 4'd5;
      tick();
      tick();
      tick();
      cmd_valid = 1'b0;
      tick();
      rd_addr = 4'd5;
      tick();
      check("fwd_value", int'(rd_data), 3);
      check("fwd_total", int'(total), 3);

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].addr, vecs[i].data);
         tick();
         rd_addr = vecs[i].addr;
         tick();
         check($sformatf("vec%0d_value", i), int'(rd_data), int'(vecs[i].exp_val));
         check($sformatf("vec%0d_total", i), int'(total), int'(vecs[i].exp_tot));
      end

      // Read-first: readout sampled on the write edge returns the old value
      rd_addr = 4'd0;
      issue(ON, 4'd0, 4'd0);
      tick();
      check("read_first_old", int'(rd_data), 14);
      tick();
      check("read_first_new", int'(rd_data), 15);
      check("read_first_total", int'(total), 20);

      // Clear coinciding with an accepted command in a stream
      issue(ON, 4'd3, 4'd0);
      cmd_valid = 1'b1;
      cmd_op    = ON;
      cmd_addr  = 4'd4;
      clear_req = 1'b1;
      tick();
      cmd_valid = 1'b0;
      clear_req = 1'b0;
      check("clear_total", int'(total), 0);
      check("clear_busy",  int'(init_busy), 1);
      check("clear_ready", int'(cmd_ready), 0);
      tick();
      check("clear_total_discard", int'(total), 0);
      count_busy(cnt);
      check("clear_busy_cycles", cnt + 1, 16);
      check_all_zero("clear_cells_zero");
      check("post_clear_ready", int'(cmd_ready), 1);
      issue(ON, 4'd9, 4'd0);
      tick();
      check("post_clear_total", int'(total), 1);

      // Reset pulse in the middle of a sweep
      issue(WR, 4'd12, 4'd6);
      tick();
      check("pre_reset_total", int'(total), 7);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midsweep_reset_busy",  int'(init_busy), 1);
      check("midsweep_reset_total", int'(total), 0);
      count_busy(cnt);
      check("midsweep_busy_cycles", cnt, 16);
      check_all_zero("midsweep_cells_zero");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
